pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 106, giving the width of the stage payload (all bundled control and data fields, concatenated).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, which is loaded into every payload register on reset and zero-extended or truncated to DATA_W.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
REQ-005 Port flush, input, 1 bit: discards all buffered beats (branch-taken squash).
REQ-006 Port in_valid, input, 1 bit: upstream beat present.
REQ-007 Port in_data, input, DATA_W bits: upstream payload.
REQ-008 Port in_ready, output, 1 bit: block accepts a beat this cycle; driven directly from a register.
REQ-009 Port out_valid, output, 1 bit: downstream beat present.
REQ-010 Port out_data, output, DATA_W bits: downstream payload; driven directly from a register.
REQ-011 Port out_ready, input, 1 bit: downstream accepts; low means downstream stall.
REQ-012 Port stall_cnt, output, 16 bits: downstream stall-cycle counter (see Configuration).

Function
REQ-013 Accept SHALL equal in_valid & in_ready; send SHALL equal out_valid & out_ready; each is a transfer of exactly one beat.
REQ-014 The block SHALL hold a main entry (drives out_data) and one skid entry, with states EMPTY, ONE and TWO.
REQ-015 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; out_valid SHALL be 0 in EMPTY and 1 in ONE and TWO.
REQ-016 EMPTY: on accept, main<=in_data and go to ONE; otherwise stay in EMPTY.
REQ-017 ONE: on accept with send, main<=in_data and stay in ONE; on accept without send, skid<=in_data and go to TWO; on send without accept, go to EMPTY; otherwise hold.
REQ-018 TWO: on send, main<=skid and go to ONE; otherwise hold; no accept is possible.
REQ-019 Latency SHALL be 1 cycle, from accept in EMPTY to out_valid; throughput SHALL be 1 beat per cycle when out_ready is held at 1.
REQ-020 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated, except by flush.
REQ-021 flush==1 SHALL take the next state to EMPTY regardless of in_valid and out_ready; a beat offered during flush SHALL be discarded, and the payload registers keep their contents.
REQ-022 If flush and reset are asserted in the same cycle, reset SHALL take priority.
REQ-023 out_data SHALL be stable while out_valid==1 and out_ready==0.

Reset
REQ-024 On reset: the state SHALL go to EMPTY, out_valid=0, in_ready=1, main and skid SHALL be set to RESET_VALUE, and stall_cnt=0.
REQ-025 Reset asserted mid-operation, including in TWO, SHALL discard all beats; the first cycle after reset is released SHALL behave as EMPTY.

Configuration
REQ-026 With macro PIPE_STAGE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 each cycle with out_valid==1 and out_ready==0, saturate at 16'hFFFF, and clear only on reset.
REQ-027 With PIPE_STAGE_STALL_CNT_EN undefined, the counter logic SHALL be absent and stall_cnt SHALL be constant 0; all other behaviour is identical.

Verification
REQ-028 Streaming: out_ready=1, in_valid=1 with in_data=1,2,3,... for 8 cycles -> out_data=1..8 on consecutive cycles, starting 1 cycle after the first accept, and in_ready stays 1.
REQ-029 Skid: accept A, then accept B with out_ready=0 -> state TWO, in_ready=0, out_data=A held; raise out_ready -> A, then B, with no loss.
REQ-030 Flush: in TWO with in_valid=1, in_data=C, flush=1 -> next cycle out_valid=0, in_ready=1, and C never appears at the output.
REQ-031 Reset: in TWO, assert reset=0 for 1 cycle -> out_valid=0, out_data=RESET_VALUE, in_ready=1; with reset=0 and flush=1 together -> result identical.
REQ-032 Counter, with the macro defined: hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cnt=5; preload near saturation and stall 3 more cycles past 16'hFFFF -> stall_cnt remains 16'hFFFF; with the macro undefined -> stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer for a pipeline stage: main entry drives out_data, skid entry absorbs one beat of stall.
// Latency: 1 cycle from accept (in EMPTY) to out_valid; sustains 1 beat/cycle when out_ready is held high.
// Backpressure: in_ready drops only when both entries are full; optional stall counter via PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_buffer #(
  parameter int DATA_W      = 106,
  parameter     RESET_VALUE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [15:0]       stall_cnt
);

  // Reset payload, zero-extended or truncated to the payload width.
  localparam logic [DATA_W-1:0] RST_DATA = DATA_W'($unsigned(RESET_VALUE));

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid;
  logic              accept;
  logic              send;

  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

  // Occupancy FSM with registered handshake outputs; out_data is the main entry itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= RST_DATA;
      skid      <= RST_DATA;
    end else if (flush) begin
      // Squash: drop occupancy only, payload registers keep their contents.
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            state     <= ONE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && send) begin
            out_data <= in_data;
          end else if (accept) begin
            skid      <= in_data;
            state     <= TWO;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end else if (send) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (send) begin
            out_data  <= skid;
            state     <= ONE;
            in_ready  <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of cycles where a beat is presented but downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Testbench for pipe_stage_buffer: directed scenarios plus random traffic against a queue-based model.
// Latency: outputs checked each falling edge against the model state after the preceding rising edge.
// Backpressure: out_ready and flush/reset randomized; model tracks stall count when the counter is built in.
module tb_pipe_stage_buffer;

  localparam int          DW = 106;
  localparam logic [31:0] RV = 32'hA5A5_1234;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [15:0]   stall_cnt;

  pipe_stage_buffer #(.DATA_W(DW), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ordered list of beats held by the stage (capacity 2).
  logic [DW-1:0] mq[$];
  logic [15:0]   m_cnt = 16'h0000;
  bit            m_rst_data = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
    if (mq.size() > 0) chk("out_data", 128'(out_data), 128'(mq[0]));
    else if (m_rst_data) chk("out_data_rst", 128'(out_data), 128'(DW'(RV)));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [DW-1:0] d, input logic ordy);
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = ordy;
    if (!r) begin
      mq.delete();
      m_cnt      = 16'h0000;
      m_rst_data = 1'b1;
    end else begin
`ifdef PIPE_STAGE_STALL_CNT_EN
      if (mq.size() > 0 && !ordy && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h0001;
`endif
      if (f) begin
        mq.delete();
      end else begin
        bit acc, snd;
        acc = v && (mq.size() < 2);
        snd = (mq.size() > 0) && ordy;
        if (snd) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(d);
          m_rst_data = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input logic ordy);
    step(1'b1, 1'b0, 1'b0, '0, ordy);
  endtask

  task automatic fill_two(input logic [DW-1:0] a, input logic [DW-1:0] b);
    step(1'b1, 1'b0, 1'b1, a, 1'b0);
    step(1'b1, 1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset state.
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_out_data", 128'(out_data), 128'(DW'(RV)));

    // Streaming: 1..8 back to back with downstream always ready.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 1'b1, DW'(i), 1'b1);
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_rdy", 128'(in_ready), 128'(1));
    end
    idle(1'b1);
    chk("stream_drain", 128'(out_valid), 128'(0));

    // Skid: second beat lands in the skid entry while downstream stalls.
    a = {42'h155, 64'hAAAA_0000_0000_0001};
    b = {42'h2AA, 64'h5555_0000_0000_0002};
    fill_two(a, b);
    chk("skid_rdy", 128'(in_ready), 128'(0));
    chk("skid_hold", 128'(out_data), 128'(a));
    step(1'b1, 1'b0, 1'b1, DW'(99), 1'b0);
    chk("skid_hold2", 128'(out_data), 128'(a));
    step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("skid_b", 128'(out_data), 128'(b));
    idle(1'b1);
    chk("skid_empty", 128'(out_valid), 128'(0));

    // Flush in TWO with a beat offered; it must never appear.
    c = DW'(32'hC0C0_C0C0);
    fill_two(DW'(11), DW'(12));
    step(1'b1, 1'b1, 1'b1, c, 1'b0);
    chk("flush_vld", 128'(out_valid), 128'(0));
    chk("flush_rdy", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Reset in TWO, then reset together with flush.
    fill_two(DW'(21), DW'(22));
    step(1'b0, 1'b0, 1'b1, DW'(23), 1'b0);
    chk("rst2_vld", 128'(out_valid), 128'(0));
    chk("rst2_data", 128'(out_data), 128'(DW'(RV)));
    chk("rst2_rdy", 128'(in_ready), 128'(1));
    fill_two(DW'(31), DW'(32));
    step(1'b0, 1'b1, 1'b1, DW'(33), 1'b1);
    chk("rstfl_vld", 128'(out_valid), 128'(0));
    chk("rstfl_data", 128'(out_data), 128'(DW'(RV)));
    chk("rstfl_rdy", 128'(in_ready), 128'(1));

    // Stall counter: five stalled cycles with a beat present.
    step(1'b1, 1'b0, 1'b1, DW'(41), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall5", 128'(stall_cnt), 128'(5));
    for (int i = 0; i < 65535 - 5 + 3; i++) idle(1'b0);
    chk("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
`else
    chk("stall_off", 128'(stall_cnt), 128'(0));
`endif
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, f, v, o;
      r = ($urandom_range(63) != 0);
      f = ($urandom_range(31) == 0);
      v = ($urandom_range(9) < 7);
      o = ($urandom_range(9) < 6);
      step(r, f, v, {$urandom, $urandom, $urandom, $urandom}, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
